// File: rtl/boolean_aa_pkg.sv
// Shared types, constants and helpers for the boolean_aa 3-input truth-table evaluator.
package boolean_aa_pkg;

    typedef logic [7:0] tt_t;

    localparam tt_t TT_MAJORITY = 8'hE8;
    localparam int  MINTERMS    = 8;

    // Minterm numbering puts a in the MSB so the index matches truth-table bit order.
    function automatic logic [2:0] minterm_idx(input logic a, input logic b, input logic c);
        return {a, b, c};
    endfunction

endpackage

// File: rtl/boolean_aa_sat_cnt.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
module boolean_aa_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Count register: clears on reset, steps on inc unless already saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/boolean_aa_core.sv
// Registered 3-input Boolean function evaluator with a reloadable truth table.
// Define BOOLEAN_AA_HIST_EN to add per-minterm saturating hit counters and their read port.
module boolean_aa_core
    import boolean_aa_pkg::*;
#(
    parameter tt_t TT_DEFAULT = TT_MAJORITY
`ifdef BOOLEAN_AA_HIST_EN
    ,
    parameter int  CNT_W      = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             in_valid,
    input  logic             tt_we,
    input  logic [7:0]       tt_wdata,
    output logic             d,
    output logic             out_valid,
    output logic [2:0]       idx,
    output logic [7:0]       tt
`ifdef BOOLEAN_AA_HIST_EN
    ,
    input  logic [2:0]       cnt_rd_sel,
    output logic [CNT_W-1:0] cnt_rd_data
`endif
);

    tt_t        tt_r;
    logic       d_r;
    logic       out_valid_r;
    logic [2:0] idx_r;

    logic [2:0] idx_s;
    logic       d_s;

    // Next-state selection; a/b/c are never looked at unless in_valid, so X inputs stay contained.
    always_comb begin
        idx_s = 3'b000;
        d_s   = 1'b0;
        if (in_valid) begin
            idx_s = minterm_idx(a, b, c);
            d_s   = tt_r[idx_s];
        end else begin
            idx_s = idx_r;
            d_s   = d_r;
        end
    end

    // Truth-table register; a same-cycle evaluation still reads the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_r <= TT_DEFAULT;
        end else if (tt_we) begin
            tt_r <= tt_wdata;
        end
    end

    // Output pipeline register: one-cycle latency, d/idx hold across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r         <= 1'b0;
            out_valid_r <= 1'b0;
            idx_r       <= 3'b000;
        end else begin
            d_r         <= d_s;
            out_valid_r <= in_valid;
            idx_r       <= idx_s;
        end
    end

    assign d         = d_r;
    assign out_valid = out_valid_r;
    assign idx       = idx_r;
    assign tt        = tt_r;

`ifdef BOOLEAN_AA_HIST_EN
    logic [CNT_W-1:0] cnt_s [MINTERMS];

    for (genvar i = 0; i < MINTERMS; i++) begin : g_hist
        logic inc_s;

        assign inc_s = in_valid && (idx_s == 3'(i));

        boolean_aa_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_s),
            .count (cnt_s[i])
        );
    end

    assign cnt_rd_data = cnt_s[cnt_rd_sel];
`endif

endmodule

// File: tb/tb_boolean_aa_core.sv
// Self-checking bench for boolean_aa_core; covers the hit counters when BOOLEAN_AA_HIST_EN is defined.
module tb_boolean_aa_core;

`ifdef BOOLEAN_AA_HIST_EN
    localparam int CW = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, c;
    logic       in_valid;
    logic       tt_we;
    logic [7:0] tt_wdata;
    logic       d;
    logic       out_valid;
    logic [2:0] idx;
    logic [7:0] tt;
`ifdef BOOLEAN_AA_HIST_EN
    logic [2:0]    cnt_rd_sel;
    logic [CW-1:0] cnt_rd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_tt;
    logic       m_d;
    logic [2:0] m_idx;
    logic       m_ov;
    int         hits [8];

    always #5 clk = ~clk;

`ifdef BOOLEAN_AA_HIST_EN
    boolean_aa_core #(
        .TT_DEFAULT (8'hE8),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .c           (c),
        .in_valid    (in_valid),
        .tt_we       (tt_we),
        .tt_wdata    (tt_wdata),
        .d           (d),
        .out_valid   (out_valid),
        .idx         (idx),
        .tt          (tt),
        .cnt_rd_sel  (cnt_rd_sel),
        .cnt_rd_data (cnt_rd_data)
    );
`else
    boolean_aa_core #(
        .TT_DEFAULT (8'hE8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .in_valid  (in_valid),
        .tt_we     (tt_we),
        .tt_wdata  (tt_wdata),
        .d         (d),
        .out_valid (out_valid),
        .idx       (idx),
        .tt        (tt)
    );
`endif

    function automatic logic majority(input logic [2:0] s);
        return (int'(s[2]) + int'(s[1]) + int'(s[0])) >= 2;
    endfunction

    function automatic logic parity3(input logic [2:0] s);
        return ((int'(s[2]) + int'(s[1]) + int'(s[0])) % 2) == 1;
    endfunction

    task automatic model_reset();
        m_tt  = 8'hE8;
        m_d   = 1'b0;
        m_idx = 3'b000;
        m_ov  = 1'b0;
        for (int k = 0; k < 8; k++) hits[k] = 0;
    endtask

    // Drives one cycle of stimulus, advances the model, returns 1 time unit after the edge.
    task automatic drive(input logic v, input logic [2:0] abc, input logic we, input logic [7:0] wd);
        in_valid = v;
        {a, b, c} = abc;
        tt_we    = we;
        tt_wdata = wd;
        if (v) begin
            m_d   = m_tt[abc];
            m_idx = abc;
            hits[abc] = hits[abc] + 1;
        end
        m_ov = v;
        if (we) m_tt = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
        in_valid = 1'b0; tt_we = 1'b0; tt_wdata = 8'h00;
`ifdef BOOLEAN_AA_HIST_EN
        cnt_rd_sel = 3'd0;
`endif
        #3;
        n_checks++;
        if (d !== 1'b0 || out_valid !== 1'b0 || idx !== 3'd0 || tt !== 8'hE8) begin
            n_fail++;
            $display("FAIL reset_state: d=%b ov=%b idx=%0d tt=%h, required d=0 ov=0 idx=0 tt=e8", d, out_valid, idx, tt);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_default_sweep();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            s = 3'(i);
            drive(1'b1, s, 1'b0, 8'h00);
            n_checks++;
            if (d !== majority(s) || idx !== s || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL default_sweep[%0d]: d=%b idx=%0d ov=%b, required d=%b idx=%0d ov=1", i, d, idx, out_valid, majority(s), s);
            end
        end
    endtask

    task automatic test_reprogram();
        drive(1'b0, 3'd0, 1'b1, 8'h96);
        n_checks++;
        if (tt !== 8'h96 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reprogram_write: tt=%h ov=%b, required tt=96 ov=0", tt, out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            s = 3'(i);
            drive(1'b1, s, 1'b0, 8'h00);
            n_checks++;
            if (d !== parity3(s) || idx !== s || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL xor_sweep[%0d]: d=%b idx=%0d ov=%b, required d=%b idx=%0d ov=1", i, d, idx, out_valid, parity3(s), s);
            end
        end
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 3'b111, 1'b1, 8'h00);
        n_checks++;
        if (d !== 1'b1 || tt !== 8'h00) begin
            n_fail++;
            $display("FAIL same_cycle_old_table: d=%b tt=%h, required d=1 tt=00", d, tt);
        end
        drive(1'b1, 3'b111, 1'b0, 8'h00);
        n_checks++;
        if (d !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_new_table: d=%b, required d=0", d);
        end
    endtask

    task automatic test_gaps();
        drive(1'b1, 3'b011, 1'b1, 8'hE8);
        drive(1'b1, 3'b011, 1'b0, 8'h00);
        n_checks++;
        if (d !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_setup: d=%b ov=%b, required d=1 ov=1", d, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'bxxx, 1'b0, 8'h00);
            n_checks++;
            if (out_valid !== 1'b0 || d !== 1'b1 || idx !== 3'b011 || $isunknown(d)) begin
                n_fail++;
                $display("FAIL gap_hold[%0d]: ov=%b d=%b idx=%b, required ov=0 d=1 idx=011", i, out_valid, d, idx);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 3'd0, 1'b1, 8'h96);
        drive(1'b1, 3'd1, 1'b0, 8'h00);
        drive(1'b1, 3'd2, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        n_checks++;
        if (d !== 1'b0 || out_valid !== 1'b0 || tt !== 8'hE8 || idx !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: d=%b ov=%b tt=%h idx=%0d, required d=0 ov=0 tt=e8 idx=0", d, out_valid, tt, idx);
        end
        #1;
        rst = 1'b0;
        model_reset();
        drive(1'b1, 3'b011, 1'b0, 8'h00);
        n_checks++;
        if (d !== 1'b1 || out_valid !== 1'b1 || idx !== 3'b011) begin
            n_fail++;
            $display("FAIL post_reset_eval: d=%b ov=%b idx=%b, required d=1 ov=1 idx=011", d, out_valid, idx);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int n = 0; n < 300; n++) begin
            logic       v, we;
            logic [2:0] s;
            logic [7:0] wd;
            v  = ($urandom_range(0, 3) != 0);
            s  = 3'($urandom_range(0, 7));
            we = ($urandom_range(0, 7) == 0);
            wd = 8'($urandom);
            drive(v, s, we, wd);
            n_checks++;
            if (out_valid !== m_ov || d !== m_d || idx !== m_idx || tt !== m_tt) begin
                n_fail++;
                $display("FAIL random[%0d]: ov=%b d=%b idx=%0d tt=%h, required ov=%b d=%b idx=%0d tt=%h",
                         n, out_valid, d, idx, tt, m_ov, m_d, m_idx, m_tt);
            end
        end
`ifdef BOOLEAN_AA_HIST_EN
        for (int k = 0; k < 8; k++) begin
            int exp_cnt;
            exp_cnt = (hits[k] > 3) ? 3 : hits[k];
            cnt_rd_sel = 3'(k);
            #1;
            n_checks++;
            if (int'(cnt_rd_data) != exp_cnt) begin
                n_fail++;
                $display("FAIL random_hist[%0d]: got %0d, required %0d", k, cnt_rd_data, exp_cnt);
            end
        end
`endif
    endtask

`ifdef BOOLEAN_AA_HIST_EN
    task automatic test_hist();
        reset_dut();
        for (int i = 0; i < 5; i++) drive(1'b1, 3'b101, 1'b0, 8'h00);
        drive(1'b0, 3'd0, 1'b1, 8'h3C);
        for (int k = 0; k < 8; k++) begin
            int exp_cnt;
            exp_cnt = (k == 5) ? 3 : 0;
            cnt_rd_sel = 3'(k);
            #1;
            n_checks++;
            if (int'(cnt_rd_data) != exp_cnt) begin
                n_fail++;
                $display("FAIL hist_sat[%0d]: got %0d, required %0d", k, cnt_rd_data, exp_cnt);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_sweep();
        test_reprogram();
        test_same_cycle();
        test_gaps();
        test_async_reset();
        test_random();
`ifdef BOOLEAN_AA_HIST_EN
        test_hist();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
